clock_gen: RTL and testbench
============================

CLOCK_GEN -- requirements
Module: clock_gen

Interface
REQ-001 The parameter DIVISOR SHALL default to 24 and SHALL set the number of fpga_clk cycles per clk_out half-period; it is an integer of at least 1.
REQ-002 The parameter COUNT_W SHALL default to 32 and SHALL set the width of cycle_count.
REQ-003 fpga_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 enable  input  1  SHALL request clk_out generation when high.
REQ-006 clk_out  output  1  SHALL be the divided clock, driven directly from a register.
REQ-007 rise_strobe  output  1  SHALL be a one-cycle pulse marking each clk_out 0->1 transition.
REQ-008 fall_strobe  output  1  SHALL be a one-cycle pulse marking each clk_out 1->0 transition.
REQ-009 cycle_count  output  COUNT_W  SHALL count the number of clk_out rising edges.

Function
REQ-010 The internal counter SHALL be ceil(log2(DIVISOR+1)) bits wide and SHALL count 0..DIVISOR-1.
REQ-011 On a counting cycle where the counter equals DIVISOR-1, the counter SHALL reload to 0 and clk_out SHALL toggle on the same edge; otherwise the counter SHALL increment by 1.
REQ-012 Output frequency SHALL be f(fpga_clk)/(2*DIVISOR) at 50% duty; DIVISOR=24 with a 48 MHz clock gives 1 MHz.
REQ-013 A counting cycle SHALL be any cycle with enable=1, or any cycle with clk_out=1 regardless of enable.
- Disabling therefore always completes the current high half-period, so no runt high pulse occurs.
REQ-014 While enable=0 and clk_out=0, the counter SHALL hold at 0 and clk_out SHALL stay 0.
REQ-015 When enable rises with clk_out=0, the first clk_out rise SHALL occur after exactly DIVISOR counting cycles.
- A low half-period interrupted by disable restarts from 0 when enable returns.
REQ-016 rise_strobe SHALL be 1 in exactly the cycle where registered clk_out first reads 1 after a toggle, and 0 otherwise.
REQ-017 fall_strobe SHALL behave as rise_strobe, but for the cycle where registered clk_out first reads 0 after a toggle.
REQ-018 rise_strobe and fall_strobe SHALL never be asserted together.
REQ-019 cycle_count SHALL increment by 1 on the edge where clk_out toggles 0->1, and SHALL wrap from 2^COUNT_W-1 to 0 with no flag.
REQ-020 With DIVISOR=1, clk_out SHALL toggle on every counting cycle, and the strobes SHALL alternate each cycle.

Reset
REQ-021 reset SHALL take priority over enable and all counting.
REQ-022 While reset=1, the counter SHALL be 0, clk_out 0, rise_strobe 0, fall_strobe 0 and cycle_count 0.
REQ-023 A reset asserted mid high-phase SHALL force clk_out low on that edge without asserting fall_strobe.
REQ-024 The first cycle after reset deasserts SHALL be treated as counter=0, clk_out=0.

Structure
REQ-025 A shared package SHALL hold the default DIVISOR (24) and COUNT_W (32) constants.
REQ-026 clock_gen SHALL be a single module with one natural sub-module, edge_strobe, which derives rise_strobe and fall_strobe from clk_out and a delayed copy of it.
REQ-027 clock_gen SHALL instantiate no vendor primitives (SB_IO, SB_HFOSC); clocking and pins stay at the top level.

Verification
REQ-028 DIVISOR=24, reset released, enable=1 -> first clk_out rise 24 cycles after release, then period 48 cycles with 24 high, and rise_strobe once per period.
REQ-029 DIVISOR=24, enable dropped 5 cycles into a high phase -> clk_out stays high 19 more cycles, falls with fall_strobe=1, then stays low; re-enable gives the next rise after 24 cycles.
REQ-030 Reset asserted 10 cycles into a high phase -> clk_out=0 and cycle_count=0 on the next edge, with both strobes 0.
REQ-031 DIVISOR=1, enable=1 for 20 cycles -> clk_out alternates every cycle and cycle_count=10.
REQ-032 COUNT_W=4, 17 rising edges of clk_out -> cycle_count=1 (wrapped).
REQ-033 enable toggled while clk_out=0 and the counter is at 7 -> counter returns to 0, and a full 24-cycle low phase precedes the next rise.

Source files
------------

// File: rtl/clock_gen_pkg.sv
// Shared constants for the clock divider: default division ratio and cycle-counter width.
package clock_gen_pkg;

  localparam int unsigned DefaultDivisor = 24;
  localparam int unsigned DefaultCountW  = 32;

  // Width of a counter that must hold values 0..divisor.
  function automatic int unsigned cnt_width(input int unsigned divisor);
    return $clog2(divisor + 1);
  endfunction

endpackage

// File: rtl/clock_gen_edge_strobe.sv
// Derives one-cycle rise/fall pulses from a registered level and a delayed copy of it.
module clock_gen_edge_strobe (
  input  logic fpga_clk,
  input  logic reset,
  input  logic level,
  output logic rise,
  output logic fall
);

  logic level_dly_q;

  // Clearing the delayed copy on reset keeps a forced-low clk_out from producing a fall pulse.
  always_ff @(posedge fpga_clk) begin
    if (reset) begin
      level_dly_q <= 1'b0;
    end else begin
      level_dly_q <= level;
    end
  end

  always_comb begin
    rise = level & ~level_dly_q;
    fall = ~level & level_dly_q;
  end

endmodule

// File: rtl/clock_gen.sv
// Divides fpga_clk by 2*DIVISOR into a 50% duty clk_out with edge strobes and a rising-edge count.
module clock_gen
  import clock_gen_pkg::*;
#(
  parameter int unsigned DIVISOR = DefaultDivisor,
  parameter int unsigned COUNT_W = DefaultCountW
) (
  input  logic               fpga_clk,
  input  logic               reset,
  input  logic               enable,
  output logic               clk_out,
  output logic               rise_strobe,
  output logic               fall_strobe,
  output logic [COUNT_W-1:0] cycle_count
);

  localparam int unsigned    CntW   = cnt_width(DIVISOR);
  localparam logic [CntW-1:0] CntMax = CntW'(DIVISOR - 1);

  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               clk_q, clk_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               counting;

  // A high half-period always runs to completion, so disabling never leaves a runt pulse.
  always_comb begin
    counting = enable | clk_q;
    cnt_d    = cnt_q;
    clk_d    = clk_q;
    count_d  = count_q;
    if (!counting) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      cnt_d = '0;
      clk_d = ~clk_q;
      if (!clk_q) begin
        count_d = count_q + COUNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge fpga_clk) begin
    if (reset) begin
      cnt_q   <= '0;
      clk_q   <= 1'b0;
      count_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      clk_q   <= clk_d;
      count_q <= count_d;
    end
  end

  clock_gen_edge_strobe edge_strobe (
    .fpga_clk (fpga_clk),
    .reset    (reset),
    .level    (clk_q),
    .rise     (rise_strobe),
    .fall     (fall_strobe)
  );

  assign clk_out     = clk_q;
  assign cycle_count = count_q;

endmodule

// File: tb/tb_clock_gen.sv
// Directed bench for clock_gen: default divider, divide-by-1 and a narrow wrapping counter.
module tb_clock_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst24, en24, c24, r24, f24;
  logic [31:0] n24;
  logic        rst1, en1, c1, r1, f1;
  logic [31:0] n1;
  logic        rstw, enw, cw, rw, fw;
  logic [3:0]  nw;

  int vectors = 0;
  int miscompares = 0;

  clock_gen dut24 (
    .fpga_clk    (clk),
    .reset       (rst24),
    .enable      (en24),
    .clk_out     (c24),
    .rise_strobe (r24),
    .fall_strobe (f24),
    .cycle_count (n24)
  );

  clock_gen #(.DIVISOR(1)) dut1 (
    .fpga_clk    (clk),
    .reset       (rst1),
    .enable      (en1),
    .clk_out     (c1),
    .rise_strobe (r1),
    .fall_strobe (f1),
    .cycle_count (n1)
  );

  clock_gen #(.DIVISOR(3), .COUNT_W(4)) dutw (
    .fpga_clk    (clk),
    .reset       (rstw),
    .enable      (enw),
    .clk_out     (cw),
    .rise_strobe (rw),
    .fall_strobe (fw),
    .cycle_count (nw)
  );

  task automatic test_reset();
    rst24 = 1'b1;
    en24  = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      vectors++;
      if ({c24, r24, f24, n24} !== 35'd0) begin
        miscompares++;
        $display("FAIL reset k=%0d got c/r/f/n=%b%b%b/%0d want 000/0", k, c24, r24, f24, n24);
      end
    end
  endtask

  task automatic test_run();
    logic ec, er, ef;
    logic [31:0] exp_n;
    rst24 = 1'b0;
    en24  = 1'b1;
    for (int k = 1; k <= 120; k++) begin
      @(negedge clk);
      ec    = ((k / 24) % 2) == 1;
      er    = (k % 48) == 24;
      ef    = (k % 48) == 0;
      exp_n = 32'((k + 24) / 48);
      vectors++;
      if ({c24, r24, f24, n24} !== {ec, er, ef, exp_n}) begin
        miscompares++;
        $display("FAIL run k=%0d got c/r/f/n=%b%b%b/%0d want %b%b%b/%0d",
                 k, c24, r24, f24, n24, ec, er, ef, exp_n);
      end
    end
  endtask

  task automatic test_disable();
    logic ec, er, ef;
    logic [31:0] exp_n;
    repeat (5) @(negedge clk);
    vectors++;
    if ({c24, n24} !== {1'b1, 32'd3}) begin
      miscompares++;
      $display("FAIL dis_pre got c/n=%b/%0d want 1/3", c24, n24);
    end
    en24 = 1'b0;
    for (int j = 1; j <= 49; j++) begin
      @(negedge clk);
      ec = j < 19;
      ef = j == 19;
      vectors++;
      if ({c24, r24, f24, n24} !== {ec, 1'b0, ef, 32'd3}) begin
        miscompares++;
        $display("FAIL disable j=%0d got c/r/f/n=%b%b%b/%0d want %b0%b/3",
                 j, c24, r24, f24, n24, ec, ef);
      end
    end
    en24 = 1'b1;
    for (int j = 1; j <= 24; j++) begin
      @(negedge clk);
      ec    = j == 24;
      er    = j == 24;
      exp_n = (j == 24) ? 32'd4 : 32'd3;
      vectors++;
      if ({c24, r24, f24, n24} !== {ec, er, 1'b0, exp_n}) begin
        miscompares++;
        $display("FAIL reenable j=%0d got c/r/f/n=%b%b%b/%0d want %b%b0/%0d",
                 j, c24, r24, f24, n24, ec, er, exp_n);
      end
    end
  endtask

  task automatic test_reset_mid();
    repeat (10) @(negedge clk);
    vectors++;
    if (c24 !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_pre got c=%b want 1", c24);
    end
    rst24 = 1'b1;
    for (int j = 1; j <= 2; j++) begin
      @(negedge clk);
      vectors++;
      if ({c24, r24, f24, n24} !== 35'd0) begin
        miscompares++;
        $display("FAIL reset_mid j=%0d got c/r/f/n=%b%b%b/%0d want 000/0", j, c24, r24, f24, n24);
      end
    end
  endtask

  task automatic test_restart();
    logic ec;
    rst24 = 1'b0;
    en24  = 1'b1;
    repeat (7) @(negedge clk);
    en24 = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      vectors++;
      if ({c24, r24, f24} !== 3'b000) begin
        miscompares++;
        $display("FAIL idle j=%0d got c/r/f=%b%b%b want 000", j, c24, r24, f24);
      end
    end
    en24 = 1'b1;
    for (int j = 1; j <= 24; j++) begin
      @(negedge clk);
      ec = j == 24;
      vectors++;
      if ({c24, r24, n24} !== {ec, ec, (j == 24) ? 32'd1 : 32'd0}) begin
        miscompares++;
        $display("FAIL restart j=%0d got c/r/n=%b%b/%0d want %b%b/%0d",
                 j, c24, r24, n24, ec, ec, (j == 24) ? 1 : 0);
      end
    end
  endtask

  task automatic test_div1();
    logic ec;
    logic [31:0] exp_n;
    rst1 = 1'b0;
    en1  = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      ec    = (k % 2) == 1;
      exp_n = 32'((k + 1) / 2);
      vectors++;
      if ({c1, r1, f1, n1} !== {ec, ec, ~ec, exp_n}) begin
        miscompares++;
        $display("FAIL div1 k=%0d got c/r/f/n=%b%b%b/%0d want %b%b%b/%0d",
                 k, c1, r1, f1, n1, ec, ec, ~ec, exp_n);
      end
    end
    en1 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      vectors++;
      if ({c1, r1, f1, n1} !== {3'b000, 32'd10}) begin
        miscompares++;
        $display("FAIL div1_off k=%0d got c/r/f/n=%b%b%b/%0d want 000/10", k, c1, r1, f1, n1);
      end
    end
  endtask

  task automatic test_wrap();
    logic [3:0] exp_n;
    rstw = 1'b0;
    enw  = 1'b1;
    for (int k = 1; k <= 99; k++) begin
      @(negedge clk);
      if (k == 87 || k == 93 || k == 99) begin
        exp_n = (k == 87) ? 4'd15 : (k == 93) ? 4'd0 : 4'd1;
        vectors++;
        if ({cw, rw, fw, nw} !== {3'b110, exp_n}) begin
          miscompares++;
          $display("FAIL wrap k=%0d got c/r/f/n=%b%b%b/%0d want 110/%0d",
                   k, cw, rw, fw, nw, exp_n);
        end
      end
    end
  endtask

  initial begin
    rst24 = 1'b1;
    en24  = 1'b0;
    rst1  = 1'b1;
    en1   = 1'b0;
    rstw  = 1'b1;
    enw   = 1'b0;
    test_reset();
    test_run();
    test_disable();
    test_reset_mid();
    test_restart();
    test_div1();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
